// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller built around one fullAdder cell.
// Adds two WIDTH-bit operands one bit per clock, LSB first, with a
// start/ready/done handshake, abort, and held result/flag registers.
// Optional build macro: SERIAL_ADD_SUB_EN adds a 'sub' input that turns the
// operation into A-B (B inverted, carry-in forced to 1).

// One-bit full adder cell shared by the serial datapath.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             b_bit;
    logic             fa_sum;
    logic             fa_cout;
    logic             load_carry;

`ifdef SERIAL_ADD_SUB_EN
    logic             sub_q, sub_d;

    // Subtraction inverts each B bit on its way into the adder and seeds the carry with 1.
    always_comb begin
        b_bit      = b_q[0] ^ sub_q;
        load_carry = sub ? 1'b1 : cin;
    end
`else
    // Addition only: B bits pass straight through and the carry seed is cin.
    always_comb begin
        b_bit      = b_q[0];
        load_carry = cin;
    end
`endif

    fullAdder u_fa (
        .a    (a_q[0]),
        .b    (b_bit),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Next-state and datapath update: accept in IDLE, one bit per cycle in RUN, publish on the last bit.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef SERIAL_ADD_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    carry_d = load_carry;
                    cnt_d   = '0;
`ifdef SERIAL_ADD_SUB_EN
                    sub_d   = sub;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    res_d   = {fa_sum, res_q[WIDTH-1:1]};
                    carry_d = fa_cout;
                    a_d     = {1'b0, a_q[WIDTH-1:1]};
                    b_d     = {1'b0, b_q[WIDTH-1:1]};
                    if (cnt_q == LAST_BIT) begin
                        sum_d   = {fa_sum, res_q[WIDTH-1:1]};
                        cout_d  = fa_cout;
                        ovf_d   = carry_q ^ fa_cout;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign ready    = (state_q == IDLE);
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl at WIDTH=8.
// Expected results are pushed when a start is accepted and popped on done.
module tb_serial_add_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic         abort;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif

    exp_t exp_q[$];
    exp_t e;
    int   pass_cnt;
    int   total_cnt;
    int   done_cnt;
    int   cycles;
    int   snap;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub),
`endif
        .a        (a),
        .b        (b),
        .cin      (cin),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        exp_t         r;
        logic [W-1:0] yy;
        logic [W:0]   full;
        yy     = sb ? ~y : y;
        full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic pop_expected();
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else begin
            e.sum = 'x; e.cout = 1'bx; e.ovf = 1'bx;
        end
    endtask

    // Drive one start pulse (we are 1ns after an edge) and push the model result.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic sb);
        a = x; b = y; cin = ci; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub = sb;
`endif
        exp_q.push_back(model(x, y, ci, sb));
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; cin = $urandom_range(0, 1);
    endtask

    // Wait (bounded) for done; cycles = edges since acceptance, -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        total_cnt++; if (ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy, done); else pass_cnt++;
        total_cnt++; if ({sum, cout, overflow} !== '0) $display("[TB] FAIL reset_result: got %h/%b/%b expected 00/0/0", sum, cout, overflow); else pass_cnt++;
    endtask

    task automatic test_basic_add();
        start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        total_cnt++; if (busy !== 1'b1 || ready !== 1'b0) $display("[TB] FAIL basic_busy: got busy=%b ready=%b expected 1/0", busy, ready); else pass_cnt++;
        wait_done(cycles);
        total_cnt++; if (cycles != W) $display("[TB] FAIL basic_latency: got %0d expected %0d", cycles, W); else pass_cnt++;
        pop_expected();
        total_cnt++; if (sum !== e.sum || cout !== e.cout || overflow !== e.ovf) $display("[TB] FAIL basic_result: got %h/%b/%b expected %h/%b/%b", sum, cout, overflow, e.sum, e.cout, e.ovf); else pass_cnt++;
        total_cnt++; if (sum !== 8'h96 || cout !== 1'b0 || overflow !== 1'b1) $display("[TB] FAIL basic_const: got %h/%b/%b expected 96/0/1", sum, cout, overflow); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (ready !== 1'b1 || done !== 1'b0) $display("[TB] FAIL basic_ready_after: got ready=%b done=%b expected 1/0", ready, done); else pass_cnt++;
    endtask

    task automatic test_carry_cases();
        logic [W-1:0] xs [2];
        logic [W-1:0] ys [2];
        logic         cs [2];
        xs[0] = 8'hFF; ys[0] = 8'h01; cs[0] = 1'b0;
        xs[1] = 8'h7F; ys[1] = 8'h00; cs[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_op(xs[k], ys[k], cs[k], 1'b0);
            wait_done(cycles);
            pop_expected();
            total_cnt++; if (cycles != W || sum !== e.sum || cout !== e.cout || overflow !== e.ovf) $display("[TB] FAIL carry_case%0d: got %h/%b/%b in %0d expected %h/%b/%b in %0d", k, sum, cout, overflow, cycles, e.sum, e.cout, e.ovf, W); else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_ignored();
        snap = done_cnt;
        start_op(8'h11, 8'h22, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #0 a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(cycles);
        pop_expected();
        total_cnt++; if (sum !== e.sum || sum !== 8'h33) $display("[TB] FAIL ignored_sum: got %h expected 33", sum); else pass_cnt++;
        repeat (12) @(posedge clk);
        #1;
        total_cnt++; if (done_cnt - snap != 1) $display("[TB] FAIL ignored_done_count: got %0d expected 1", done_cnt - snap); else pass_cnt++;
    endtask

    task automatic test_abort();
        snap = done_cnt;
        start_op(8'h05, 8'h06, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #0 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        void'(exp_q.pop_back());
        total_cnt++; if (ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL abort_idle: got ready=%b busy=%b expected 1/0", ready, busy); else pass_cnt++;
        total_cnt++; if (sum !== 8'h33) $display("[TB] FAIL abort_sum_held: got %h expected 33", sum); else pass_cnt++;
        repeat (12) @(posedge clk);
        #1;
        total_cnt++; if (done_cnt != snap) $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", done_cnt - snap); else pass_cnt++;
        start_op(8'h44, 8'h11, 1'b0, 1'b0);
        wait_done(cycles);
        pop_expected();
        total_cnt++; if (cycles != W || sum !== e.sum) $display("[TB] FAIL abort_then_add: got %h in %0d expected %h in %0d", sum, cycles, e.sum, W); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_start_abort_idle();
        abort = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL idle_abort: got ready=%b busy=%b expected 1/0", ready, busy); else pass_cnt++;
        start_op(8'h3A, 8'hC7, 1'b1, 1'b0);
        abort = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL start_with_abort: got busy=%b expected 1", busy); else pass_cnt++;
        wait_done(cycles);
        pop_expected();
        total_cnt++; if (sum !== e.sum || cout !== e.cout || overflow !== e.ovf) $display("[TB] FAIL start_with_abort_result: got %h/%b/%b expected %h/%b/%b", sum, cout, overflow, e.sum, e.cout, e.ovf); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        snap = done_cnt;
        start_op(8'hAA, 8'h55, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #0 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        void'(exp_q.pop_back());
        total_cnt++; if (ready !== 1'b1 || busy !== 1'b0 || {sum, cout, overflow} !== '0) $display("[TB] FAIL midrun_reset: got ready=%b busy=%b %h/%b/%b expected 1/0 00/0/0", ready, busy, sum, cout, overflow); else pass_cnt++;
        repeat (12) @(posedge clk);
        #1;
        total_cnt++; if (done_cnt != snap) $display("[TB] FAIL midrun_reset_no_done: got %0d pulses expected 0", done_cnt - snap); else pass_cnt++;
        start_op(8'h01, 8'h01, 1'b0, 1'b0);
        wait_done(cycles);
        pop_expected();
        total_cnt++; if (sum !== e.sum || sum !== 8'h02) $display("[TB] FAIL midrun_reset_next: got %h expected 02", sum); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            wait_done(cycles);
            pop_expected();
            total_cnt++; if (cycles != W || sum !== e.sum || cout !== e.cout || overflow !== e.ovf) $display("[TB] FAIL b2b_%0d: got %h/%b/%b in %0d expected %h/%b/%b in %0d", k, sum, cout, overflow, cycles, e.sum, e.cout, e.ovf, W); else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_subtract();
        start_op(8'h10, 8'h20, 1'b0, 1'b1);
        wait_done(cycles);
        pop_expected();
        total_cnt++; if (sum !== 8'hF0 || cout !== 1'b0 || overflow !== 1'b0 || sum !== e.sum) $display("[TB] FAIL sub_a: got %h/%b/%b expected f0/0/0", sum, cout, overflow); else pass_cnt++;
        @(posedge clk); #1;
        start_op(8'h80, 8'h01, 1'b0, 1'b1);
        wait_done(cycles);
        pop_expected();
        total_cnt++; if (sum !== 8'h7F || cout !== 1'b1 || overflow !== 1'b1 || sum !== e.sum) $display("[TB] FAIL sub_b: got %h/%b/%b expected 7f/1/1", sum, cout, overflow); else pass_cnt++;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        pass_cnt = 0; total_cnt = 0; done_cnt = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        test_reset();
        test_basic_add();
        test_carry_cases();
        test_start_ignored();
        test_abort();
        test_start_abort_idle();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_subtract();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Sequences one instance of the team's 1-bit full adder cell (fullAdder) over WIDTH cycles to add two WIDTH-bit operands.
- Provides a start/ready/done handshake, abort, and a result/flag hold register.
- Serves as the area-minimal add unit for lab datapaths that can accept multi-cycle latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an add; sampled only when ready=1.
- abort  input  1  cancel an in-flight add; effective only in RUN.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  carry-in; latched on accepted start.
- ready  output  1  high in IDLE; the block can accept start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; the result registers were just updated.
- sum  output  WIDTH  result; holds the last completed add.
- cout  output  1  carry out of bit WIDTH-1 of the last completed add.
- overflow  output  1  signed overflow of the last completed add (carry into MSB XOR carry out of MSB).

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values (after the edge with reset=1): state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, overflow=0, bit counter=0, carry flop=0. Reset overrides start and abort.
- All outputs are registered or decoded directly from the state register. There are no combinational paths from inputs to outputs.
- States are IDLE, RUN, DONE:
  - IDLE: start=1 at edge t → latch a, b into shift registers, load carry flop with cin, counter=0, go to RUN.
  - RUN: each cycle the full adder takes A[0], B[0] and the carry flop. Its sum bit shifts into the MSB of the result shift register, its carry-out updates the carry flop, the operand registers shift right, and the counter increments.
  - RUN exit: when counter=WIDTH-1 (bit processed at edge t+WIDTH), go to DONE. At that same edge, load sum from the result shift register, cout from the final carry, and overflow from carry-into-MSB XOR final carry.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: start accepted at edge t → done=1 during the cycle after edge t+WIDTH → ready=1 again after edge t+WIDTH+1.
- start in RUN or DONE is ignored: no queueing and no effect on the operation in flight.
- abort=1 in RUN → IDLE at the next edge. sum, cout and overflow keep their previous values, and no done pulse is produced.
- abort in IDLE or DONE is ignored. If abort and start are both high in IDLE, start is accepted.
- Reset asserted mid-RUN → all registers return to their reset values and no done pulse is produced.
- The counter is log2(WIDTH)-wide, rounded up, and never wraps in normal operation. The RUN exit compare is exact (counter==WIDTH-1).
- Operand inputs are don't-care except at the accepting edge.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN
- Defined:
  - Adds input port sub (1 bit), latched on accepted start.
  - If the latched sub=1, each B bit is inverted before entering the full adder and the carry flop is loaded with 1 (cin ignored). The result is A-B.
  - cout is then the not-borrow flag; overflow is computed with the same formula as for addition.
- Undefined: the sub port does not exist and the block performs addition only.

Test Plan:
- WIDTH=8, reset 2 cycles, then a=0x5A, b=0x3C, cin=0, start=1 for one cycle at edge t → busy=1 for 8 cycles; done=1 in the cycle after edge t+8; sum=0x96, cout=0, overflow=1; ready=1 after edge t+9.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0, overflow=1.
- Start an add with a=0x11, b=0x22. Pulse start again at RUN cycle 4 with different operands → second start ignored; sum=0x33 and exactly one done pulse.
- Abort at RUN cycle 3 after a previous result of 0x33 → IDLE next edge, ready=1, no done, sum stays 0x33. A new start afterwards completes normally.
- Assert reset mid-RUN → outputs at reset values after that edge (sum=0, ready=1), no done. A following start of 0x01+0x01 gives sum=0x02.
- SERIAL_ADD_SUB_EN defined, sub=1, a=0x10, b=0x20, cin=0 → sum=0xF0, cout=0, overflow=0. Then sub=1, a=0x80, b=0x01 → sum=0x7F, cout=1, overflow=1.
